dac_sample_sched: RTL
=====================

# dac_sample_sched

Paced sample scheduler in front of the dual-channel DAC interface. It owns the output sample rate. Two sample requesters (e.g. waveform generator and DSP playback) share the two DAC channels. At each rate tick the block grants at most one requester per channel, using round-robin arbitration. It registers the granted samples onto the DAC data bus and counts underruns when a channel has no fresh sample.

## Interface
Parameters:
- DATA_W, 14, sample width (matches DAC data bus)
- DIV_W, 16, rate divider width
- CNT_W, 16, underrun counter width
- MIDSCALE, 14'h2000, idle/reset output code

Ports:
- DAC_CLK  in  1  DAC clock; all logic on posedge
- DAC_RST  in  1  synchronous, active-high reset
- SCHED_EN  in  1  scheduler enable
- RATE_DIV  in  DIV_W  tick period minus one, in DAC_CLK cycles
- REQ0_VALID  in  1  requester 0 has a sample
- REQ0_CH  in  1  target channel, 0=A, 1=B
- REQ0_DATA  in  DATA_W  requester 0 sample
- REQ0_READY  out  1  sample accepted this cycle
- REQ1_VALID / REQ1_CH / REQ1_DATA / REQ1_READY  same as requester 0
- CLR_UNDERRUN  in  1  clear both underrun counters
- DAC_DATA_A  out  DATA_W  channel A sample to DAC
- DAC_DATA_B  out  DATA_W  channel B sample to DAC
- DAC_UPDATE  out  1  one-cycle pulse when DAC_DATA_A/B were just loaded
- UNDERRUN_A  out  CNT_W  channel A underrun count
- UNDERRUN_B  out  CNT_W  channel B underrun count

## Operation
- Rate counter `cnt`:
  - With SCHED_EN=1: `tick = (cnt >= RATE_DIV)`. On tick, cnt←0; otherwise cnt←cnt+1.
  - With SCHED_EN=0: cnt←0 and tick=0.
  - RATE_DIV=0 gives a tick every cycle. Changing RATE_DIV mid-count takes effect on the next compare; the `>=` compare prevents wrap-around stalls.
- Per-channel arbitration happens only in tick cycles.
  - A requester is a candidate for channel c when its VALID=1 and CH=c.
  - One candidate: it is granted.
  - Two candidates: grant `prio_c` (1 bit per channel; reset value 0). After a contested grant, `prio_c` ← index of the loser. Uncontested grants leave prio unchanged.
  - When the two requesters target different channels, both are granted in the same tick.
- READY is combinational: `REQk_READY = tick & grant_k`. It is never asserted outside tick cycles. A requester holds VALID/CH/DATA stable until it sees READY.
- Output registers:
  - On tick, a channel with a grant loads the granted DATA.
  - A channel without a candidate holds its previous value and records an underrun.
  - DAC_UPDATE←tick, registered, so it coincides with the new register values.
- SCHED_EN=0: DAC_DATA_A/B←MIDSCALE on the next edge and READY=0. Underrun counters and prio hold their values.
- Underrun counters:
  - Increment by 1 on a tick with no candidate for that channel, saturating at all-ones.
  - CLR_UNDERRUN synchronously clears both counters. Clear wins over a simultaneous increment.

## Timing
- Reset values (DAC_RST=1): cnt=0, prio_A=prio_B=0, DAC_DATA_A=DAC_DATA_B=MIDSCALE, DAC_UPDATE=0, UNDERRUN_A=UNDERRUN_B=0. Combinationally, REQ0_READY=REQ1_READY=0.
- After reset release with SCHED_EN=1, the first tick occurs RATE_DIV cycles later (cycle index RATE_DIV, counting the first post-reset cycle as 0). Ticks then recur every RATE_DIV+1 cycles.
- Latency: READY in cycle N; sample on DAC_DATA_x and DAC_UPDATE=1 in cycle N+1.
- Reset mid-operation: outputs return to reset values on the same edge. An in-flight READY is dropped; the requester sees no handshake.
- SCHED_EN falling in a tick cycle suppresses that tick.

## Configuration
- DAC_SCHED_UNDERRUN_CNT_EN
  - Defined: underrun counters and CLR_UNDERRUN logic are present, as described above.
  - Undefined: counters are not built, UNDERRUN_A/B are tied to 0 and CLR_UNDERRUN is ignored. All other behaviour is identical.

## Structure
- Shared package `dac_pkg`: DATA_W, MIDSCALE, channel constants CH_A=0 and CH_B=1, and the sample type `logic [DATA_W-1:0]`.
- One sub-module, `dac_rate_tick`: holds the rate counter and the enable/compare, and outputs `tick`.
- Arbitration, output registers and counters live in the top module.

## Test plan
- Reset then SCHED_EN=1, RATE_DIV=3, no requests:
  - DAC_DATA_A/B=14'h2000.
  - Ticks at post-reset cycles 3, 7, 11.
  - UNDERRUN_A=UNDERRUN_B=3 after cycle 12.
- RATE_DIV=0, REQ0 (CH=A, 14'h0123) and REQ1 (CH=B, 14'h3FFF) held valid:
  - Both READY every cycle.
  - Next cycle DAC_DATA_A=14'h0123, DAC_DATA_B=14'h3FFF, DAC_UPDATE=1.
- Both requesters target channel A, held valid, RATE_DIV=1:
  - Grants alternate REQ0, REQ1, REQ0 on successive ticks.
  - UNDERRUN_B increments every tick.
- UNDERRUN_A at 16'hFFFE, three empty ticks:
  - Count reaches 16'hFFFF and stays there.
  - CLR_UNDERRUN asserted together with an empty tick leaves the count at 0.
- SCHED_EN dropped mid-stream with REQ0 valid:
  - READY never asserts.
  - DAC_DATA_A=14'h2000 one cycle later.
  - Re-enable gives the first tick RATE_DIV cycles after SCHED_EN rises.
- DAC_RST asserted in a tick cycle with READY=1:
  - Outputs return to reset values at the next edge.
  - No DAC_UPDATE pulse.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared DAC-side constants and types: sample width, idle code and channel indices.
package dac_pkg;

    localparam int DATA_W = 14;
    localparam logic [DATA_W-1:0] MIDSCALE = 14'h2000;
    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    typedef logic [DATA_W-1:0] sample_t;

endpackage

// File: rtl/dac_rate_tick.sv
// Output-rate pacing counter; tick marks the cycles in which samples are scheduled.
module dac_rate_tick #(
    parameter int DIV_W = 16
) (
    input  logic             DAC_CLK,
    input  logic             DAC_RST,
    input  logic             sched_en,
    input  logic [DIV_W-1:0] rate_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r;

    // Gated by reset so a handshake can never be offered while the block is being reset.
    assign tick = sched_en & ~DAC_RST & (cnt_r >= rate_div);

    // Rate counter: restarts on tick or while disabled.
    always_ff @(posedge DAC_CLK) begin
        if (DAC_RST) begin
            cnt_r <= '0;
        end else if (!sched_en || tick) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/dac_sample_sched.sv
// Paced two-requester / two-channel DAC sample scheduler with round-robin arbitration.
// Underrun counters are built only when DAC_SCHED_UNDERRUN_CNT_EN is defined.
module dac_sample_sched #(
    parameter int                 DATA_W   = dac_pkg::DATA_W,
    parameter int                 DIV_W    = 16,
    parameter int                 CNT_W    = 16,
    parameter logic [DATA_W-1:0]  MIDSCALE = dac_pkg::MIDSCALE
) (
    input  logic              DAC_CLK,
    input  logic              DAC_RST,
    input  logic              SCHED_EN,
    input  logic [DIV_W-1:0]  RATE_DIV,
    input  logic              REQ0_VALID,
    input  logic              REQ0_CH,
    input  logic [DATA_W-1:0] REQ0_DATA,
    output logic              REQ0_READY,
    input  logic              REQ1_VALID,
    input  logic              REQ1_CH,
    input  logic [DATA_W-1:0] REQ1_DATA,
    output logic              REQ1_READY,
    input  logic              CLR_UNDERRUN,
    output logic [DATA_W-1:0] DAC_DATA_A,
    output logic [DATA_W-1:0] DAC_DATA_B,
    output logic              DAC_UPDATE,
    output logic [CNT_W-1:0]  UNDERRUN_A,
    output logic [CNT_W-1:0]  UNDERRUN_B
);

    import dac_pkg::*;

    logic              tick_s;
    logic              prio_a_r;
    logic              prio_b_r;
    logic              cand0_a_s;
    logic              cand1_a_s;
    logic              cand0_b_s;
    logic              cand1_b_s;
    logic              grant0_a_s;
    logic              grant1_a_s;
    logic              grant0_b_s;
    logic              grant1_b_s;
    logic              empty_a_s;
    logic              empty_b_s;
    logic [DATA_W-1:0] data_a_s;
    logic [DATA_W-1:0] data_b_s;

    dac_rate_tick #(
        .DIV_W (DIV_W)
    ) u_rate_tick (
        .DAC_CLK  (DAC_CLK),
        .DAC_RST  (DAC_RST),
        .sched_en (SCHED_EN),
        .rate_div (RATE_DIV),
        .tick     (tick_s)
    );

    // Candidate detection and per-channel round-robin grant; prio names the favoured requester.
    always_comb begin
        cand0_a_s  = REQ0_VALID & (REQ0_CH == CH_A);
        cand1_a_s  = REQ1_VALID & (REQ1_CH == CH_A);
        cand0_b_s  = REQ0_VALID & (REQ0_CH == CH_B);
        cand1_b_s  = REQ1_VALID & (REQ1_CH == CH_B);
        grant0_a_s = cand0_a_s & (~cand1_a_s | (prio_a_r == 1'b0));
        grant1_a_s = cand1_a_s & (~cand0_a_s | (prio_a_r == 1'b1));
        grant0_b_s = cand0_b_s & (~cand1_b_s | (prio_b_r == 1'b0));
        grant1_b_s = cand1_b_s & (~cand0_b_s | (prio_b_r == 1'b1));
        empty_a_s  = ~(cand0_a_s | cand1_a_s);
        empty_b_s  = ~(cand0_b_s | cand1_b_s);
    end

    // Granted-sample mux per channel; holds the current output when nothing is granted.
    always_comb begin
        data_a_s = DAC_DATA_A;
        data_b_s = DAC_DATA_B;
        if (grant0_a_s) begin
            data_a_s = REQ0_DATA;
        end else if (grant1_a_s) begin
            data_a_s = REQ1_DATA;
        end else begin
            data_a_s = DAC_DATA_A;
        end
        if (grant0_b_s) begin
            data_b_s = REQ0_DATA;
        end else if (grant1_b_s) begin
            data_b_s = REQ1_DATA;
        end else begin
            data_b_s = DAC_DATA_B;
        end
    end

    assign REQ0_READY = tick_s & (grant0_a_s | grant0_b_s);
    assign REQ1_READY = tick_s & (grant1_a_s | grant1_b_s);

    // Priority flips to the loser only after a contested grant.
    always_ff @(posedge DAC_CLK) begin
        if (DAC_RST) begin
            prio_a_r <= 1'b0;
            prio_b_r <= 1'b0;
        end else begin
            if (tick_s && cand0_a_s && cand1_a_s) begin
                prio_a_r <= ~prio_a_r;
            end
            if (tick_s && cand0_b_s && cand1_b_s) begin
                prio_b_r <= ~prio_b_r;
            end
        end
    end

    // DAC output registers and the update strobe aligned with them.
    always_ff @(posedge DAC_CLK) begin
        if (DAC_RST || !SCHED_EN) begin
            DAC_DATA_A <= MIDSCALE;
            DAC_DATA_B <= MIDSCALE;
            DAC_UPDATE <= 1'b0;
        end else begin
            if (tick_s) begin
                DAC_DATA_A <= data_a_s;
                DAC_DATA_B <= data_b_s;
            end
            DAC_UPDATE <= tick_s;
        end
    end

`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    logic [CNT_W-1:0] und_a_r;
    logic [CNT_W-1:0] und_b_r;

    // Saturating underrun counters; a clear overrides a same-cycle increment.
    always_ff @(posedge DAC_CLK) begin
        if (DAC_RST || CLR_UNDERRUN) begin
            und_a_r <= '0;
            und_b_r <= '0;
        end else begin
            if (tick_s && empty_a_s && !(&und_a_r)) begin
                und_a_r <= und_a_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (tick_s && empty_b_s && !(&und_b_r)) begin
                und_b_r <= und_b_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign UNDERRUN_A = und_a_r;
    assign UNDERRUN_B = und_b_r;
`else
    logic unused_s;
    assign unused_s   = CLR_UNDERRUN ^ empty_a_s ^ empty_b_s;
    assign UNDERRUN_A = '0;
    assign UNDERRUN_B = '0;
`endif

endmodule
